fetch_prefetch_stage: RTL and testbench
=======================================

// Module: fetch_prefetch_stage
// PURPOSE
//  Next-generation fetch stage. Replaces single-request fetch with a decoupled prefetcher: up to
//  MAX_OUTSTANDING pipelined OBI reads on the instruction port, responses buffered with their PC
//  in a FETCH_DEPTH-entry FIFO. Feeds the decode stage through valid/pc/next_pc/instr registers.
//  Branch redirects flush the buffer and discard in-flight responses.
// PARAMETERS
//  RESET_ADDR       64'h0  first fetch address after reset
//  FETCH_DEPTH      4      prefetch FIFO entries (power of 2, >=2)
//  MAX_OUTSTANDING  2      max granted-but-not-returned OBI reads (1..FETCH_DEPTH)
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   reset, asynchronous, active-high
//  squash_i       in   1   invalidate instruction loaded into output regs this cycle
//  stall_i        in   1   hold output regs; prefetching continues
//  target_sel_i   in   1   `PC_SRC_BRANCH => redirect to target_addr_i this cycle
//  target_addr_i  in   64  redirect target (bits[1:0] ignored, treated as 0)
//  imem_req_o     out  1   OBI request
//  imem_gnt_i     in   1   OBI grant
//  imem_addr_o    out  64  OBI address, word aligned
//  imem_we_o      out  1   tied 0
//  imem_be_o      out  4   tied 4'hF
//  imem_wdata_o   out  32  tied 0
//  imem_rvalid_i  in   1   OBI response valid
//  imem_rdata_i   in   32  OBI read data
//  imem_stall_ao  out  1   comb: FIFO empty (next output load would be a bubble)
//  valid_o        out  1   output instruction valid
//  pc_o           out  64  PC of instr_o
//  next_pc_o      out  64  pc_o + 4 (return address)
//  instr_o        out  32  fetched instruction
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_ADDR, out_cnt=0, discard_cnt=0, FIFO empty, req_pending=0,
//   redir_pending=0; valid_o=0, pc_o=0, next_pc_o=0, instr_o=0, imem_req_o=0.
//  Issue: imem_req_o=1 when req_pending, or when out_cnt<MAX_OUTSTANDING and
//   out_cnt+fifo_cnt<FETCH_DEPTH (space reserved for every response). imem_addr_o=fetch_pc.
//  OBI rule: once req is high without gnt, req and addr hold until gnt (req_pending=1).
//  On req&gnt: out_cnt+1; fetch_pc+=4 (wraps mod 2^64). Same-cycle gnt & rvalid: out_cnt unchanged.
//  Response: on rvalid, out_cnt-1. If discard_cnt>0: drop and discard_cnt-1.
//   Otherwise push {pc,rdata}; FIFO tracks response PCs in issue order.
//  Redirect (target_sel_i==`PC_SRC_BRANCH), same clock edge:
//   - flush FIFO; discard_cnt = out_cnt after this cycle's gnt/rvalid updates.
//     A same-cycle rvalid is dropped; a same-cycle granted request is counted for discard.
//   - no ungranted req pending: fetch_pc=target.
//   - ungranted req pending: redir_pending=1, target latched. On its gnt, discard_cnt+1 and
//     fetch_pc=latched target. A later redirect overwrites the latched target.
//   - earliest target fetch: req in N+1; with 0-wait gnt/rvalid, FIFO push end of N+2,
//     valid_o=1 at N+3.
//  Output regs on each edge:
//   - stall_i=1: hold all (priority over squash_i).
//   - else if FIFO non-empty and no redirect: pop head; valid_o=~squash_i;
//     pc_o/instr_o=head; next_pc_o=head.pc+4.
//   - else: valid_o=0, pc/instr hold.
//   - redirect same cycle as non-stalled load: valid_o=0, no pop (FIFO flushed).
//  FIFO full: no new issue (credit rule). Push into full FIFO cannot occur; assertion in sim.
//  Stall: FIFO fills to FETCH_DEPTH, then issue stops; no loss.
//  Counters: out_cnt/discard_cnt width $clog2(MAX_OUTSTANDING+1); discard_cnt<=out_cnt always.
// STRUCTURE
//  Lucid64.vh holds `PC_SRC_BRANCH, `RESET_ADDR default, OBI width defines.
//  Sub-module fetch_fifo (sync FIFO, WIDTH=96, DEPTH=FETCH_DEPTH; push/pop/flush/count/full/empty).
//  Top: issue/credit logic, redirect/discard counters, output regs.
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle later -> addrs 0,4,8,..; valid_o from cycle 3; pc_o +4/cycle.
//  2 stall_i high 10 cycles, FETCH_DEPTH=4 -> exactly 4 reqs beyond outstanding; outputs held;
//    on release pc_o resumes with no gap/dup.
//  3 Redirect to 0x1000 with 2 outstanding (pc 0x8,0xC) -> both rdata dropped;
//    first valid pc_o=0x1000, instr=mem[0x1000].
//  4 gnt held 0 for 3 cycles at addr 0x10, redirect to 0x200 in cycle 2 -> addr stays 0x10
//    until gnt; that response dropped; next req addr=0x200.
//  5 Redirect and rvalid same cycle, plus squash_i with stall_i=0 -> rvalid data never appears;
//    squashed load gives valid_o=0.
//  6 Assert rst_i mid-burst with 2 outstanding -> outputs 0 immediately (async); late rvalid
//    after release ignored (out_cnt=0); fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/fetch_prefetch_stage_pkg.sv
// Shared constants and types for the decoupled prefetching fetch stage.
// Redirect source encoding, OBI widths and the buffered {pc, instr} entry layout.
package fetch_prefetch_stage_pkg;

  localparam logic        PC_SRC_BRANCH      = 1'b1;
  localparam logic [63:0] RESET_ADDR_DEFAULT = 64'h0;

  localparam int unsigned OBI_ADDR_W = 64;
  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_BE_W   = 4;

  typedef struct packed {
    logic [OBI_ADDR_W-1:0] pc;
    logic [OBI_DATA_W-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_prefetch_stage_fifo.sv
// Synchronous prefetch FIFO holding fetched {pc, instr} entries in issue order.
// Flush empties it in one cycle; storage itself is not reset.
module fetch_prefetch_stage_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & ~empty_o;

  assign count_o = count_q;
  assign full_o  = (32'(count_q) == DEPTH);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Credit accounting upstream guarantees a slot for every response.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o && !flush_i));

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Decoupled fetch stage: pipelined OBI instruction reads with credit-based issue,
// a prefetch FIFO, redirect flush with in-flight discard, and decode-facing output regs.
module fetch_prefetch_stage
  import fetch_prefetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_ADDR      = RESET_ADDR_DEFAULT,
  parameter int unsigned FETCH_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  squash_i,
  input  logic                  stall_i,
  input  logic                  target_sel_i,
  input  logic [63:0]           target_addr_i,
  output logic                  imem_req_o,
  input  logic                  imem_gnt_i,
  output logic [OBI_ADDR_W-1:0] imem_addr_o,
  output logic                  imem_we_o,
  output logic [OBI_BE_W-1:0]   imem_be_o,
  output logic [OBI_DATA_W-1:0] imem_wdata_o,
  input  logic                  imem_rvalid_i,
  input  logic [OBI_DATA_W-1:0] imem_rdata_i,
  output logic                  imem_stall_ao,
  output logic                  valid_o,
  output logic [63:0]           pc_o,
  output logic [63:0]           next_pc_o,
  output logic [31:0]           instr_o
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned FCNT_W = $clog2(FETCH_DEPTH+1);

  logic [63:0]       fetch_pc_q, fetch_pc_d;
  logic [63:0]       rsp_pc_q, rsp_pc_d;
  logic [63:0]       redir_target_q, redir_target_d;
  logic [63:0]       target_aligned;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  discard_cnt_q, discard_cnt_d, discard_base;
  logic              req_pending_q, req_pending_d;
  logic              redir_pending_q, redir_pending_d;
  logic              redirect, credit_ok, gnt_fire, rsp_valid, rsp_drop_old;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_cnt;
  fetch_entry_t      push_entry, head_entry;

  assign imem_we_o    = 1'b0;
  assign imem_be_o    = '1;
  assign imem_wdata_o = '0;

  assign redirect       = (target_sel_i == PC_SRC_BRANCH);
  assign target_aligned = align_word(target_addr_i);

  // Every issued read must have a guaranteed FIFO slot when it returns.
  assign credit_ok = (32'(out_cnt_q) < MAX_OUTSTANDING)
                  && ((32'(out_cnt_q) + 32'(fifo_cnt)) < FETCH_DEPTH)
                  && !fifo_full;

  assign imem_req_o    = ~rst_i & (req_pending_q | credit_ok);
  assign imem_addr_o   = fetch_pc_q;
  assign imem_stall_ao = fifo_empty;

  assign gnt_fire     = imem_req_o & imem_gnt_i;
  assign rsp_valid    = imem_rvalid_i & (out_cnt_q != '0);
  assign rsp_drop_old = rsp_valid & (discard_cnt_q != '0);

  assign fifo_push = rsp_valid & ~rsp_drop_old & ~redirect;
  assign fifo_pop  = ~stall_i & ~redirect & ~fifo_empty;

  assign push_entry = '{pc: rsp_pc_q, instr: imem_rdata_i};

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (gnt_fire && !rsp_valid) out_cnt_d = out_cnt_q + CNT_W'(1);
    else if (!gnt_fire && rsp_valid) out_cnt_d = out_cnt_q - CNT_W'(1);

    discard_base  = rsp_drop_old ? (discard_cnt_q - CNT_W'(1)) : discard_cnt_q;
    discard_cnt_d = discard_base;
    if (redirect) discard_cnt_d = out_cnt_d;
    else if (gnt_fire && redir_pending_q) discard_cnt_d = discard_base + CNT_W'(1);
  end

  // A redirect arriving while an ungranted request is on the bus must wait for that grant.
  always_comb begin
    req_pending_d   = imem_req_o & ~imem_gnt_i;
    fetch_pc_d      = fetch_pc_q;
    redir_pending_d = redir_pending_q;
    redir_target_d  = redir_target_q;
    rsp_pc_d        = rsp_pc_q;
    if (redirect) begin
      rsp_pc_d = target_aligned;
      if (imem_req_o && !imem_gnt_i) begin
        redir_pending_d = 1'b1;
        redir_target_d  = target_aligned;
      end else begin
        redir_pending_d = 1'b0;
        fetch_pc_d      = target_aligned;
      end
    end else begin
      if (gnt_fire) begin
        fetch_pc_d      = redir_pending_q ? redir_target_q : (fetch_pc_q + 64'd4);
        redir_pending_d = 1'b0;
      end
      if (fifo_push) rsp_pc_d = rsp_pc_q + 64'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q      <= RESET_ADDR;
      rsp_pc_q        <= RESET_ADDR;
      redir_target_q  <= '0;
      out_cnt_q       <= '0;
      discard_cnt_q   <= '0;
      req_pending_q   <= 1'b0;
      redir_pending_q <= 1'b0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      rsp_pc_q        <= rsp_pc_d;
      redir_target_q  <= redir_target_d;
      out_cnt_q       <= out_cnt_d;
      discard_cnt_q   <= discard_cnt_d;
      req_pending_q   <= req_pending_d;
      redir_pending_q <= redir_pending_d;
    end
  end

  fetch_prefetch_stage_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FETCH_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      pc_o      <= '0;
      next_pc_o <= '0;
      instr_o   <= '0;
    end else if (!stall_i) begin
      if (fifo_pop) begin
        valid_o   <= ~squash_i;
        pc_o      <= head_entry.pc;
        next_pc_o <= head_entry.pc + 64'd4;
        instr_o   <= head_entry.instr;
      end else begin
        valid_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Randomized bench for fetch_prefetch_stage: an in-order OBI memory slave plus a
// transaction-level reference model (queues of outstanding reads and buffered entries).
module tb_fetch_prefetch_stage;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic        drop;
  } out_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        squash_i = 1'b0, stall_i = 1'b0, target_sel_i = 1'b0;
  logic [63:0] target_addr_i = '0;
  logic        imem_req_o, imem_gnt_i = 1'b0;
  logic [63:0] imem_addr_o;
  logic        imem_we_o;
  logic [3:0]  imem_be_o;
  logic [31:0] imem_wdata_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_stall_ao, valid_o;
  logic [63:0] pc_o, next_pc_o;
  logic [31:0] instr_o;

  int checks = 0;
  int errors = 0;

  out_t        m_out[$];
  ent_t        m_fifo[$];
  logic [63:0] slave_q[$];
  logic [63:0] m_fetch_pc, m_rtgt, m_pc, m_next;
  logic [31:0] m_instr;
  logic        m_pend, m_rpend, m_valid;
  bit          spur_rvalid = 0;

  fetch_prefetch_stage #(
    .RESET_ADDR      (64'h0),
    .FETCH_DEPTH     (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .squash_i      (squash_i),
    .stall_i       (stall_i),
    .target_sel_i  (target_sel_i),
    .target_addr_i (target_addr_i),
    .imem_req_o    (imem_req_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_addr_o   (imem_addr_o),
    .imem_we_o     (imem_we_o),
    .imem_be_o     (imem_be_o),
    .imem_wdata_o  (imem_wdata_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .imem_stall_ao (imem_stall_ao),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .next_pc_o     (next_pc_o),
    .instr_o       (instr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579BDF;
  endfunction

  function automatic bit m_req();
    return m_pend || (m_out.size() < MAXO && (m_out.size() + m_fifo.size()) < DEPTH);
  endfunction

  task automatic model_reset();
    m_out.delete();
    m_fifo.delete();
    slave_q.delete();
    m_fetch_pc = 64'h0;
    m_rtgt = '0;
    m_pend = 0;
    m_rpend = 0;
    m_valid = 0;
    m_pc = '0;
    m_next = '0;
    m_instr = '0;
  endtask

  // Applies one clock edge of the specified behaviour, using this cycle's inputs.
  task automatic model_step(input bit req);
    bit          fire;
    bit          redir;
    logic [63:0] tgt;
    out_t        o;
    ent_t        e;
    fire  = req && imem_gnt_i;
    redir = target_sel_i;
    tgt   = {target_addr_i[63:2], 2'b00};
    if (!stall_i) begin
      if (!redir && m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        m_valid = !squash_i;
        m_pc    = e.pc;
        m_next  = e.pc + 64'd4;
        m_instr = e.instr;
      end else begin
        m_valid = 0;
      end
    end
    if (imem_rvalid_i && m_out.size() > 0) begin
      o = m_out.pop_front();
      if (!o.drop && !redir) begin
        e.pc = o.pc;
        e.instr = imem_rdata_i;
        m_fifo.push_back(e);
      end
    end
    if (fire) begin
      o.pc = m_fetch_pc;
      o.drop = m_rpend;
      m_out.push_back(o);
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_out[i]) m_out[i].drop = 1'b1;
      if (req && !imem_gnt_i) begin
        m_rpend = 1;
        m_rtgt  = tgt;
      end else begin
        m_rpend    = 0;
        m_fetch_pc = tgt;
      end
    end else if (fire) begin
      m_fetch_pc = m_rpend ? m_rtgt : (m_fetch_pc + 64'd4);
      m_rpend    = 0;
    end
    m_pend = req && !imem_gnt_i;
  endtask

  // Entered and left at posedge+1.
  task automatic run_cycles(input int n, input int gnt_pct, input int rv_pct,
                            input int redir_pct, input int stall_pct, input int squash_pct);
    bit          req;
    bit          fire_dut;
    logic [63:0] addr_dut;
    for (int c = 0; c < n; c++) begin
      imem_gnt_i   = ($urandom_range(99) < gnt_pct);
      stall_i      = ($urandom_range(99) < stall_pct);
      squash_i     = ($urandom_range(99) < squash_pct);
      target_sel_i = ($urandom_range(99) < redir_pct);
      target_addr_i = ($urandom_range(9) == 0) ? (64'hFFFF_FFFF_FFFF_FFF4 | 64'($urandom_range(3)))
                                               : {32'h0, $urandom};
      if (spur_rvalid) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = $urandom;
        spur_rvalid   = 0;
      end else if (slave_q.size() > 0 && $urandom_range(99) < rv_pct) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(slave_q[0]);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
      end
      #1;
      req = m_req();
      chk("imem_req", imem_req_o, req);
      if (req) chk("imem_addr", imem_addr_o, m_fetch_pc);
      chk("imem_stall_ao", imem_stall_ao, m_fifo.size() == 0);
      fire_dut = imem_req_o && imem_gnt_i;
      addr_dut = imem_addr_o;
      model_step(req);
      @(posedge clk_i);
      if (imem_rvalid_i && slave_q.size() > 0) void'(slave_q.pop_front());
      if (fire_dut) slave_q.push_back(addr_dut);
      #1;
      chk("valid_o", valid_o, m_valid);
      chk("pc_o", pc_o, m_pc);
      chk("next_pc_o", next_pc_o, m_next);
      chk("instr_o", instr_o, m_instr);
    end
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_next_pc", next_pc_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_req", imem_req_o, 0);
    chk("we_tied", imem_we_o, 0);
    chk("be_tied", imem_be_o, 4'hF);
    chk("wdata_tied", imem_wdata_o, 0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Zero-wait streaming, then stall-and-fill, then release.
    run_cycles(20, 100, 100, 0, 0, 0);
    run_cycles(10, 100, 100, 0, 100, 0);
    chk("stall_fifo_full_req", imem_req_o, 0);
    run_cycles(12, 100, 100, 0, 0, 0);

    // Mixed randomized traffic with redirects, stalls and squashes.
    run_cycles(2500, 70, 60, 8, 20, 10);
    run_cycles(1200, 25, 40, 12, 10, 10);
    run_cycles(800, 100, 100, 15, 5, 20);

    // Async reset with reads in flight, followed by a stray late response.
    run_cycles(4, 100, 0, 0, 0, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_pc", pc_o, 0);
    chk("arst_next_pc", next_pc_o, 0);
    chk("arst_instr", instr_o, 0);
    chk("arst_req", imem_req_o, 0);
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    spur_rvalid = 1;
    run_cycles(30, 100, 100, 0, 0, 0);
    run_cycles(500, 60, 50, 8, 15, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
